// File: rtl/router_pkg.sv
// router_pkg: shared header layout, FSM states and payload limit for the packet receiver
package router_pkg;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_MSB = 1;
  localparam int MAX_PAYLOAD = 63;
  typedef enum logic [1:0] {S_HDR, S_PAYLOAD, S_PARITY} state_t;
endpackage

// File: rtl/rx_skid_fifo.sv
// rx_skid_fifo: 2-entry 8-bit skid buffer with push/pop and occupancy count
module rx_skid_fifo (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [1:0] count
);
  logic [7:0] mem [2];
  logic wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      wp <= wp ^ push;
      rp <= rp ^ pop;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  assign dout = mem[rp];
endmodule

// File: rtl/router_pkt_receiver.sv
// router_pkt_receiver: drains one router port and reframes it into header, payload stream and parity check
module router_pkt_receiver
  import router_pkg::*;
#(
  parameter logic [1:0] PORT_ID = 2'd0,
  parameter int TIMEOUT = 32
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  output logic       read_enb,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       hdr_valid,
  output logic [5:0] hdr_len,
  output logic [1:0] hdr_addr,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       addr_err,
  output logic       timeout_err
);
  localparam int RW = $clog2(MAX_PAYLOAD + 1);
  state_t state, nxt;
  logic inflight, head_valid, to, pop, stall, beat;
  logic [7:0] head, acc, tcnt;
  logic [1:0] count;
  logic [RW-1:0] rem;
  rx_skid_fifo u_fifo (
    .clk(clock),
    .rst(reset || to),
    .push(inflight),
    .pop(pop),
    .din(data_out),
    .dout(head),
    .count(count)
  );
  always_comb begin
    head_valid = count != 2'd0;
    to = state != S_HDR && tcnt == 8'(TIMEOUT);
    stall = state == S_PAYLOAD && head_valid && !out_ready;
    read_enb = vld_out && !reset && ({1'b0, count} + {2'b0, inflight}) < 3'd2;
    hdr_valid = state == S_HDR && head_valid;
    out_valid = state == S_PAYLOAD && head_valid && !to;
    out_data = out_valid ? head : 8'd0;
    out_last = out_valid && rem == RW'(1);
    beat = out_valid && out_ready;
    pkt_done = state == S_PARITY && head_valid && !to;
    parity_err = pkt_done && acc != head;
    addr_err = hdr_valid && head[ADDR_MSB:0] != PORT_ID;
    timeout_err = to;
    pop = hdr_valid || beat || pkt_done;
    nxt = to ? S_HDR
        : hdr_valid ? (head[LEN_MSB:LEN_LSB] != '0 ? S_PAYLOAD : S_PARITY)
        : beat && rem == RW'(1) ? S_PARITY
        : pkt_done ? S_HDR
        : state;
  end
  always_ff @(posedge clock)
    state <= reset ? S_HDR : nxt;
  always_ff @(posedge clock)
    if (reset) begin
      inflight <= 1'b0;
      tcnt <= 8'd0;
      acc <= 8'd0;
      rem <= '0;
      hdr_len <= 6'd0;
      hdr_addr <= 2'd0;
    end else begin
      inflight <= read_enb && !to;
      tcnt <= (state == S_HDR || to || inflight || stall) ? 8'd0 : tcnt + 8'd1;
      if (hdr_valid) begin
        hdr_len <= head[LEN_MSB:LEN_LSB];
        hdr_addr <= head[ADDR_MSB:0];
        acc <= head;
        rem <= head[LEN_MSB:LEN_LSB];
      end else if (beat) begin
        acc <= acc ^ head;
        rem <= rem - RW'(1);
      end
    end
endmodule

// File: tb/tb_router_pkt_receiver.sv
// tb_router_pkt_receiver: randomized packet scenarios checked against a byte-queue reference model
module tb_router_pkt_receiver;
  localparam int TO = 32;
  logic clock = 1'b0, reset = 1'b1, vld_out = 1'b0, out_ready = 1'b1;
  logic [7:0] data_out = 8'd0, out_data;
  logic read_enb, out_valid, out_last, hdr_valid, pkt_done, parity_err, addr_err, timeout_err;
  logic [5:0] hdr_len;
  logic [1:0] hdr_addr;
  int checks = 0, passed = 0;
  logic [7:0] src[$], exp[$], got[$];
  int hdr_cycs[$], done_cycs[$];
  int cyc = 0, outstanding = 0, consumed;
  int n_hdr, n_addr, n_last, n_done, n_perr, n_to, n_thr, last_idx, last_beat, to_cyc, viol_re, viol_stab;
  logic re_s = 1'b0, bp = 1'b0, prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  always #5 clock = ~clock;
  router_pkt_receiver #(.PORT_ID(2'd0), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .vld_out(vld_out), .data_out(data_out), .read_enb(read_enb),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .hdr_valid(hdr_valid), .hdr_len(hdr_len), .hdr_addr(hdr_addr), .pkt_done(pkt_done),
    .parity_err(parity_err), .addr_err(addr_err), .timeout_err(timeout_err)
  );
  initial forever begin
    @(negedge clock);
    re_s = read_enb;
    @(posedge clock);
    #1;
    if (re_s && src.size() > 0) data_out = src.pop_front();
    vld_out = src.size() > 0;
    out_ready = bp ? (cyc % 3 == 0) : 1'b1;
  end
  initial forever begin
    @(negedge clock);
    cyc++;
    if (reset) begin
      outstanding = 0;
      prev_stall = 1'b0;
    end else begin
      if (read_enb && outstanding >= 2) viol_re++;
      if (vld_out && outstanding < 2 && !read_enb) viol_re++;
      if (dut.u_fifo.count == 2'd3) viol_re++;
      n_thr += int'(vld_out && !read_enb);
      if (out_valid && prev_stall && out_data !== prev_data) viol_stab++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      if (hdr_valid) hdr_cycs.push_back(cyc);
      n_hdr += int'(hdr_valid);
      n_addr += int'(addr_err);
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_beat = cyc;
        if (out_last) last_idx = got.size();
      end
      n_last += int'(out_last);
      if (pkt_done) done_cycs.push_back(cyc);
      n_done += int'(pkt_done);
      n_perr += int'(parity_err);
      if (timeout_err) to_cyc = cyc;
      n_to += int'(timeout_err);
      consumed = int'(hdr_valid) + int'(out_valid && out_ready) + int'(pkt_done);
      outstanding = timeout_err ? 0 : outstanding + int'(read_enb) - consumed;
      if (outstanding < 0 || outstanding > 2) viol_re++;
    end
  end
  task automatic clear_mon();
    exp.delete(); got.delete(); hdr_cycs.delete(); done_cycs.delete();
    n_hdr = 0; n_addr = 0; n_last = 0; n_done = 0; n_perr = 0; n_to = 0; n_thr = 0;
    last_idx = 0; last_beat = 0; to_cyc = 0; viol_re = 0; viol_stab = 0;
  endtask
  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input bit bad, input int ncut);
    logic [7:0] q[$];
    logic [7:0] p, b;
    p = {len, addr};
    q.push_back(p);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      exp.push_back(b);
      q.push_back(b);
      p = p ^ b;
    end
    q.push_back(bad ? p ^ 8'h01 : p);
    for (int i = 0; i < q.size() && (ncut < 0 || i < ncut); i++) src.push_back(q[i]);
  endtask
  task automatic wait_done(input int want);
    for (int i = 0; i < 400 && n_done < want && n_to == 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
  endtask
  function automatic int beat_errs();
    int e = (got.size() > exp.size()) ? got.size() - exp.size() : exp.size() - got.size();
    for (int i = 0; i < exp.size() && i < got.size(); i++) e += int'(got[i] !== exp[i]);
    return e;
  endfunction
  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++; if ({read_enb, out_valid, out_last, hdr_valid, pkt_done, parity_err, addr_err, timeout_err, out_data, hdr_len, hdr_addr} !== 24'd0) $display("FAIL reset_outputs: got %h want 0", {read_enb, out_valid, out_last, hdr_valid, pkt_done, parity_err, addr_err, timeout_err, out_data, hdr_len, hdr_addr}); else passed++;
    @(posedge clock);
    #2 reset = 1'b0;
  endtask
  task automatic test_basic();
    clear_mon();
    send_pkt(6'd14, 2'd0, 1'b0, -1);
    wait_done(1);
    checks++; if (n_hdr !== 1) $display("FAIL basic_hdr_count: got %0d want 1", n_hdr); else passed++;
    checks++; if (hdr_len !== 6'd14) $display("FAIL basic_hdr_len: got %0d want 14", hdr_len); else passed++;
    checks++; if (beat_errs() !== 0) $display("FAIL basic_payload: got %0d bad beats want 0", beat_errs()); else passed++;
    checks++; if (last_idx !== 14 || n_last !== 1) $display("FAIL basic_last: got idx %0d count %0d want 14 1", last_idx, n_last); else passed++;
    checks++; if (n_done !== 1 || n_perr !== 0) $display("FAIL basic_done: got done %0d perr %0d want 1 0", n_done, n_perr); else passed++;
    checks++; if (n_addr !== 0 || n_to !== 0) $display("FAIL basic_errs: got addr %0d to %0d want 0 0", n_addr, n_to); else passed++;
    checks++; if (viol_re !== 0) $display("FAIL basic_read_flow: got %0d violations want 0", viol_re); else passed++;
  endtask
  task automatic test_parity_err();
    clear_mon();
    send_pkt(6'd14, 2'd0, 1'b1, -1);
    wait_done(1);
    checks++; if (beat_errs() !== 0) $display("FAIL perr_payload: got %0d bad beats want 0", beat_errs()); else passed++;
    checks++; if (n_done !== 1 || n_perr !== 1) $display("FAIL perr_flag: got done %0d perr %0d want 1 1", n_done, n_perr); else passed++;
  endtask
  task automatic test_addr_err();
    clear_mon();
    send_pkt(6'd14, 2'd1, 1'b0, -1);
    wait_done(1);
    checks++; if (n_addr !== 1 || n_hdr !== 1) $display("FAIL addr_flag: got addr %0d hdr %0d want 1 1", n_addr, n_hdr); else passed++;
    checks++; if (hdr_addr !== 2'd1) $display("FAIL addr_field: got %0d want 1", hdr_addr); else passed++;
    checks++; if (beat_errs() !== 0 || n_done !== 1 || n_perr !== 0) $display("FAIL addr_complete: got bad %0d done %0d perr %0d want 0 1 0", beat_errs(), n_done, n_perr); else passed++;
  endtask
  task automatic test_backpressure();
    clear_mon();
    bp = 1'b1;
    send_pkt(6'd14, 2'd0, 1'b0, -1);
    wait_done(1);
    bp = 1'b0;
    checks++; if (beat_errs() !== 0) $display("FAIL bp_payload: got %0d bad beats want 0", beat_errs()); else passed++;
    checks++; if (viol_stab !== 0) $display("FAIL bp_stable: got %0d changes want 0", viol_stab); else passed++;
    checks++; if (viol_re !== 0) $display("FAIL bp_read_flow: got %0d violations want 0", viol_re); else passed++;
    checks++; if (n_thr == 0) $display("FAIL bp_throttle: got %0d throttled cycles want >0", n_thr); else passed++;
    checks++; if (n_to !== 0 || n_done !== 1) $display("FAIL bp_done: got to %0d done %0d want 0 1", n_to, n_done); else passed++;
  endtask
  task automatic test_back_to_back();
    int d;
    clear_mon();
    send_pkt(6'd0, 2'd0, 1'b0, -1);
    send_pkt(6'd3, 2'd0, 1'b0, -1);
    wait_done(2);
    d = (done_cycs.size() > 0 && hdr_cycs.size() > 0) ? done_cycs[0] - hdr_cycs[0] : -1;
    checks++; if (d !== 1) $display("FAIL zl_done_latency: got %0d want 1", d); else passed++;
    checks++; if (n_done !== 2 || n_perr !== 0) $display("FAIL zl_done: got done %0d perr %0d want 2 0", n_done, n_perr); else passed++;
    checks++; if (beat_errs() !== 0 || n_last !== 1) $display("FAIL zl_payload: got bad %0d last %0d want 0 1", beat_errs(), n_last); else passed++;
    checks++; if (n_hdr !== 2 || hdr_len !== 6'd3) $display("FAIL zl_next_hdr: got hdr %0d len %0d want 2 3", n_hdr, hdr_len); else passed++;
  endtask
  task automatic test_timeout();
    int d;
    clear_mon();
    send_pkt(6'd14, 2'd0, 1'b0, 6);
    for (int i = 0; i < 100 && got.size() < 5; i++) @(posedge clock);
    for (int i = 0; i < 80 && n_to == 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    d = to_cyc - last_beat;
    checks++; if (n_to !== 1) $display("FAIL to_pulse: got %0d want 1", n_to); else passed++;
    checks++; if (!(d inside {[TO - 2:TO]})) $display("FAIL to_delay: got %0d want %0d..%0d", d, TO - 2, TO); else passed++;
    checks++; if (n_done !== 0 || got.size() !== 5) $display("FAIL to_abort: got done %0d beats %0d want 0 5", n_done, got.size()); else passed++;
    clear_mon();
    send_pkt(6'($urandom_range(1, 20)), 2'd0, 1'b0, -1);
    wait_done(1);
    checks++; if (beat_errs() !== 0 || n_done !== 1 || n_perr !== 0 || n_to !== 0) $display("FAIL to_recover: got bad %0d done %0d perr %0d to %0d want 0 1 0 0", beat_errs(), n_done, n_perr, n_to); else passed++;
  endtask
  task automatic test_reset_mid();
    clear_mon();
    send_pkt(6'd20, 2'd0, 1'b0, -1);
    for (int i = 0; i < 100 && got.size() < 6; i++) @(posedge clock);
    #2 reset = 1'b1;
    src.delete();
    @(posedge clock);
    @(negedge clock);
    checks++; if ({read_enb, out_valid, out_last, hdr_valid, pkt_done, parity_err, addr_err, timeout_err, out_data, hdr_len, hdr_addr} !== 24'd0) $display("FAIL rst_mid_outputs: got %h want 0", {read_enb, out_valid, out_last, hdr_valid, pkt_done, parity_err, addr_err, timeout_err, out_data, hdr_len, hdr_addr}); else passed++;
    @(posedge clock);
    #2 reset = 1'b0;
    clear_mon();
    send_pkt(6'($urandom_range(1, 30)), 2'd0, 1'b0, -1);
    wait_done(1);
    checks++; if (beat_errs() !== 0 || n_hdr !== 1) $display("FAIL rst_fresh_payload: got bad %0d hdr %0d want 0 1", beat_errs(), n_hdr); else passed++;
    checks++; if (n_done !== 1 || n_perr !== 0 || n_to !== 0) $display("FAIL rst_fresh_done: got done %0d perr %0d to %0d want 1 0 0", n_done, n_perr, n_to); else passed++;
  endtask
  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_addr_err();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
